cache_controller: RTL and testbench

Sequencing FSM for the direct-mapped cache datapath. It accepts one CPU word access at a time, looks up the 8-line cache array (valid bit, 9-bit tag, 32-bit data), and on a read miss fetches the word from main memory and refills the line. Writes are write-through and no-write-allocate: memory is always written, and the cache line is updated only on a hit. The block sits between the CPU-side requester and the `Cache`/`MainMemory` instances, drives all of their address, data and write controls, and keeps hit/miss statistics.

---
 rtl/cache_pkg.sv | 18 +
 rtl/cache_controller_sat_counter.sv | 24 ++
 rtl/cache_controller.sv | 120 ++++++++++++
 tb/tb_cache_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths and controller state encoding for the direct-mapped cache datapath.
package cache_pkg;

    localparam int TAG_W  = 9;
    localparam int IDX_W  = 3;
    localparam int DATA_W = 32;
    localparam int ADDR_W = TAG_W + IDX_W;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        MEM_RD = 3'd2,
        FILL   = 3'd3,
        MEM_WR = 3'd4,
        DONE   = 3'd5
    } ctrl_state_t;

endpackage

// File: rtl/cache_controller_sat_counter.sv
// Saturating up-counter used for the hit and miss statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] cnt_q;

    // Increment on request, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/cache_controller.sv
// Sequencing FSM for a write-through, no-write-allocate direct-mapped cache.
module cache_controller #(
    parameter int TAG_W  = 9,
    parameter int IDX_W  = 3,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [TAG_W+IDX_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0]      cpu_wdata,
    output logic                   cpu_busy,
    output logic                   cpu_done,
    output logic [DATA_W-1:0]      cpu_rdata,
    output logic                   cpu_hit,
    output logic [IDX_W-1:0]       cache_index,
    output logic [TAG_W-1:0]       cache_tag_in,
    output logic [DATA_W-1:0]      cache_data_in,
    output logic                   cache_write,
    input  logic                   cache_valid,
    input  logic [TAG_W-1:0]       cache_tag_out,
    input  logic [DATA_W-1:0]      cache_data_out,
    output logic [TAG_W+IDX_W-1:0] mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic                   mem_write,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic [CNT_W-1:0]       hit_count,
    output logic [CNT_W-1:0]       miss_count
);

    import cache_pkg::*;

    localparam int AW = TAG_W + IDX_W;

    ctrl_state_t       state_q;
    logic [AW-1:0]     addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              hit_q;
    logic              hit_s;
    logic              lookup_s;
    logic              fill_s;

    assign hit_s    = cache_valid && (cache_tag_out == addr_q[AW-1:IDX_W]);
    assign lookup_s = (state_q == LOOKUP);
    assign fill_s   = (state_q == FILL);

    // Request latch, state sequencing and the registered CPU read results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    hit_q <= hit_s;
                    if (we_q) begin
                        state_q <= MEM_WR;
                    end else if (hit_s) begin
                        rdata_q <= cache_data_out;
                        state_q <= DONE;
                    end else begin
                        state_q <= MEM_RD;
                    end
                end
                MEM_RD:  state_q <= FILL;
                FILL: begin
                    rdata_q <= mem_rdata;
                    state_q <= DONE;
                end
                MEM_WR:  state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // A write hit updates the line in the same cycle it is detected.
    assign cache_write   = (lookup_s && we_q && hit_s) || fill_s;
    assign cache_data_in = fill_s ? mem_rdata : wdata_q;
    assign cache_index   = addr_q[IDX_W-1:0];
    assign cache_tag_in  = addr_q[AW-1:IDX_W];
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_write     = (state_q == MEM_WR);
    assign cpu_busy      = (state_q != IDLE);
    assign cpu_done      = (state_q == DONE);
    assign cpu_rdata     = rdata_q;
    assign cpu_hit       = hit_q;

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (lookup_s && hit_s),
        .count (hit_count)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (lookup_s && !hit_s),
        .count (miss_count)
    );

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with behavioural cache array and main memory.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [11:0] cpu_addr = 12'h000;
    logic [31:0] cpu_wdata = 32'h0;
    logic        cpu_busy, cpu_done, cpu_hit, cache_write, mem_write;
    logic [31:0] cpu_rdata, cache_data_in, mem_wdata;
    logic [2:0]  cache_index;
    logic [8:0]  cache_tag_in;
    logic [11:0] mem_addr;
    logic        cache_valid;
    logic [8:0]  cache_tag_out;
    logic [31:0] cache_data_out;
    logic [31:0] mem_rdata = 32'h0;
    logic [15:0] hit_count, miss_count;

    logic        c_valid [8];
    logic [8:0]  c_tag   [8];
    logic [31:0] c_data  [8];
    logic [31:0] mem     [4096];

    int checks = 0;
    int errors = 0;
    int lat, cw_cnt, cw_cycle, mw_cnt;
    logic [8:0]  cw_tag;
    logic [31:0] cw_data;
    logic        busy1;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_busy       (cpu_busy),
        .cpu_done       (cpu_done),
        .cpu_rdata      (cpu_rdata),
        .cpu_hit        (cpu_hit),
        .cache_index    (cache_index),
        .cache_tag_in   (cache_tag_in),
        .cache_data_in  (cache_data_in),
        .cache_write    (cache_write),
        .cache_valid    (cache_valid),
        .cache_tag_out  (cache_tag_out),
        .cache_data_out (cache_data_out),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_write      (mem_write),
        .mem_rdata      (mem_rdata),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    assign cache_valid    = c_valid[cache_index];
    assign cache_tag_out  = c_tag[cache_index];
    assign cache_data_out = c_data[cache_index];

    // Cache array and memory models; preloaded while init_n is low.
    always @(posedge clk) begin
        if (!init_n) begin
            for (int i = 0; i < 8; i++) begin
                c_valid[i] <= 1'b0;
                c_tag[i]   <= 9'h000;
                c_data[i]  <= 32'h0;
            end
            c_valid[1] <= 1'b1;
            c_data[1]  <= 32'h1;
            c_valid[2] <= 1'b1;
            c_data[2]  <= 32'h22;
            for (int i = 0; i < 4096; i++) mem[i] <= 32'(i);
        end else begin
            if (cache_write) begin
                c_valid[cache_index] <= 1'b1;
                c_tag[cache_index]   <= cache_tag_in;
                c_data[cache_index]  <= cache_data_in;
            end
            if (mem_write) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic we, input logic [11:0] a, input logic [31:0] wd);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        lat = -1; cw_cnt = 0; cw_cycle = 0; mw_cnt = 0; busy1 = 1'b0;
        cw_tag = 9'h0; cw_data = 32'h0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) busy1 = cpu_busy;
            if (cache_write) begin
                cw_cnt++; cw_cycle = n; cw_tag = cache_tag_in; cw_data = cache_data_in;
            end
            if (mem_write) mw_cnt++;
            if (cpu_done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        init_n = 1'b1;
        #1;
        check("rst_busy", 32'(cpu_busy), 32'h0);
        check("rst_done", 32'(cpu_done), 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_cw", 32'(cache_write), 32'h0);
        check("rst_mw", 32'(mem_write), 32'h0);
        check("rst_hitcnt", 32'(hit_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Read hit on preloaded line 1.
        access(1'b0, 12'h001, 32'h0);
        check("rh_lat", 32'(lat), 32'd2);
        check("rh_busy", 32'(busy1), 32'h1);
        check("rh_rdata", cpu_rdata, 32'h1);
        check("rh_hit", 32'(cpu_hit), 32'h1);
        check("rh_hitcnt", 32'(hit_count), 32'h1);

        // Read miss on invalid line 3, refill from mem[3].
        access(1'b0, 12'h003, 32'h0);
        check("rm_lat", 32'(lat), 32'd4);
        check("rm_rdata", cpu_rdata, 32'h3);
        check("rm_hit", 32'(cpu_hit), 32'h0);
        check("rm_mw", 32'(mw_cnt), 32'd0);
        check("rm_cw_cnt", 32'(cw_cnt), 32'd1);
        check("rm_cw_cycle", 32'(cw_cycle), 32'd3);
        check("rm_fill_tag", 32'(cw_tag), 32'h0);
        check("rm_fill_data", cw_data, 32'h3);
        check("rm_misscnt", 32'(miss_count), 32'h1);
        check("rm_line_valid", 32'(c_valid[3]), 32'h1);

        access(1'b0, 12'h003, 32'h0);
        check("rh2_lat", 32'(lat), 32'd2);
        check("rh2_hit", 32'(cpu_hit), 32'h1);
        check("rh2_rdata", cpu_rdata, 32'h3);
        check("rh2_hitcnt", 32'(hit_count), 32'h2);

        // Write hit on line 2.
        access(1'b1, 12'h002, 32'hDEADBEEF);
        check("wh_lat", 32'(lat), 32'd3);
        check("wh_cw_cnt", 32'(cw_cnt), 32'd1);
        check("wh_cw_cycle", 32'(cw_cycle), 32'd1);
        check("wh_mw", 32'(mw_cnt), 32'd1);
        @(negedge clk);
        check("wh_mem", mem[2], 32'hDEADBEEF);
        check("wh_line", c_data[2], 32'hDEADBEEF);
        check("wh_hit", 32'(cpu_hit), 32'h1);
        check("wh_rdata_hold", cpu_rdata, 32'h3);
        check("wh_hitcnt", 32'(hit_count), 32'h3);

        // Write miss: tag 1 over line 2 holding tag 0.
        access(1'b1, 12'h00A, 32'h12345678);
        check("wm_lat", 32'(lat), 32'd3);
        check("wm_cw_cnt", 32'(cw_cnt), 32'd0);
        check("wm_mw", 32'(mw_cnt), 32'd1);
        check("wm_hit", 32'(cpu_hit), 32'h0);
        check("wm_misscnt", 32'(miss_count), 32'h2);
        check("wm_rdata_hold", cpu_rdata, 32'h3);
        @(negedge clk);
        check("wm_mem", mem[10], 32'h12345678);
        check("wm_line_data", c_data[2], 32'hDEADBEEF);
        check("wm_line_tag", 32'(c_tag[2]), 32'h0);

        // Abort a read miss on line 5 while in MEM_RD.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h005;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("ab_busy", 32'(cpu_busy), 32'h0);
        check("ab_done", 32'(cpu_done), 32'h0);
        check("ab_rdata", cpu_rdata, 32'h0);
        check("ab_hit", 32'(cpu_hit), 32'h0);
        check("ab_hitcnt", 32'(hit_count), 32'h0);
        check("ab_misscnt", 32'(miss_count), 32'h0);
        check("ab_cw", 32'(cache_write), 32'h0);
        check("ab_mw", 32'(mem_write), 32'h0);
        check("ab_index", 32'(cache_index), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("ab_line5", 32'(c_valid[5]), 32'h0);
        check("ab_line3", c_data[3], 32'h3);
        access(1'b0, 12'h001, 32'h0);
        check("ab_next_lat", 32'(lat), 32'd2);
        check("ab_next_hitcnt", 32'(hit_count), 32'h1);

        // Saturation of the hit counter.
        @(negedge clk);
        force dut.u_hit_cnt.cnt_q = 16'hFFFE;
        #1;
        release dut.u_hit_cnt.cnt_q;
        access(1'b0, 12'h001, 32'h0);
        check("sat_1", 32'(hit_count), 32'hFFFF);
        access(1'b0, 12'h001, 32'h0);
        access(1'b0, 12'h001, 32'h0);
        check("sat_3", 32'(hit_count), 32'hFFFF);
        check("sat_misscnt", 32'(miss_count), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
